// File: rtl/hex_rot_pkg.sv
// Shared types and helpers for the rotating-display rotation controller.
//   rot_state_t : controller FSM states
//   ROT_W       : width of the rotation bus fed to every shifter stage
//   rot_next()  : one rotation step, wrapping mod 4 in either direction
package hex_rot_pkg;

  localparam int ROT_W = 2;
  localparam logic [ROT_W-1:0] ROT_ONE = ROT_W'(1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } rot_state_t;

  // dir = 0 steps up, dir = 1 steps down; natural 2-bit wrap gives 3->0 and 0->3
  function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] rot,
                                                input logic             dir);
    return dir ? (rot - ROT_ONE) : (rot + ROT_ONE);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability debounce and press-edge pulse.
//   CLOCK_50    in  : sole clock
//   RESET       in  : synchronous active-high reset (button seen as released)
//   key_n       in  : raw active-low pushbutton, asynchronous and bouncy
//   press_pulse out : registered one-cycle strobe on each accepted press
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db_lvl;
  logic          db_lvl_d;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      db_lvl      <= 1'b1;
      db_lvl_d    <= 1'b1;
      db_cnt      <= '0;
      press_pulse <= 1'b0;
    end else begin
      s1       <= key_n;
      s2       <= s1;
      db_lvl_d <= db_lvl;
      // any cycle that agrees with the accepted level restarts the stability window
      if (s2 != db_lvl) begin
        if (db_cnt == DB_LAST) begin
          db_lvl <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
      // falling edge of the debounced level only; release is ignored
      press_pulse <= db_lvl_d & ~db_lvl;
    end
  end

endmodule

// File: rtl/rot_sel_ctrl.sv
// Rotation-amount generator for the 4-digit rotating display. Advances rot once per
// TICK_DIV clocks while running, or once per debounced button press, in the
// direction selected by dir.
//   CLOCK_50 in  : sole clock
//   RESET    in  : synchronous active-high reset
//   run_en   in  : 1 = auto-advance, 0 = paused
//   dir      in  : 0 = rot counts up, 1 = rot counts down (sampled at advance)
//   step_n   in  : raw active-low pushbutton
//   rot      out : rotation amount shared by all shifter stages
//   tick     out : high in the cycle rot holds a newly advanced value
//   running  out : high while in RUNNING
//
// state   | meaning
// PAUSED  | prescaler held at 0, only button presses advance rot
// RUNNING | prescaler counts 0..TICK_DIV-1, advance on terminal count or press
module rot_sel_ctrl
  import hex_rot_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             run_en,
  input  logic             dir,
  input  logic             step_n,
  output logic [ROT_W-1:0] rot,
  output logic             tick,
  output logic             running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  rot_state_t    state;
  rot_state_t    state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          step_pulse;
  logic          advance;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_debounce (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .key_n       (step_n),
    .press_pulse (step_pulse)
  );

  always_comb begin
    state_next = state;
    presc_next = '0;
    advance    = step_pulse;
    case (state)
      PAUSED: begin
        if (run_en) state_next = RUNNING;
      end
      RUNNING: begin
        // terminal count still advances even if run_en drops on this edge
        if (presc == PRE_LAST) advance = 1'b1;
        if (!run_en) state_next = PAUSED;
      end
      default: state_next = PAUSED;
    endcase
    // prescaler only counts while staying in RUNNING; any advance restarts the period
    if (state == RUNNING && run_en && !advance) presc_next = presc + PW'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= PAUSED;
      presc <= '0;
      rot   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_next;
      presc <= presc_next;
      tick  <= advance;
      if (advance) rot <= rot_next(rot, dir);
    end
  end

  assign running = (state == RUNNING);

endmodule

// File: tb/tb_rot_sel_ctrl.sv
module tb_rot_sel_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       run_en;
  logic       dir;
  logic       step_n;
  logic [1:0] rot;
  logic       tick;
  logic       running;

  typedef struct {
    logic [1:0] rot;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  rot_sel_ctrl #(
    .TICK_DIV  (8),
    .DB_CYCLES (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .run_en   (run_en),
    .dir      (dir),
    .step_n   (step_n),
    .rot      (rot),
    .tick     (tick),
    .running  (running)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input logic [1:0] r, input int c);
    exp_t e;
    e.rot = r;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    wait_clk(2);
    check("reset_rot", int'(rot), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_running", int'(running), 0);
    RESET = 1'b0;
  endtask

  // monitor: every tick must match the next scheduled advance in value and cycle
  always @(negedge CLOCK_50) begin
    if (tick) begin
      exp_t e;
      tick_cnt++;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_tick: got tick with rot=%0d at cycle %0d, expected no tick", rot, cyc);
      end else begin
        e = q.pop_front();
        check("tick_rot", int'(rot), int'(e.rot));
        check("tick_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    int d;
    int t0;
    bit bad;

    RESET  = 1'b1;
    run_en = 1'b0;
    dir    = 1'b0;
    step_n = 1'b1;

    // reset state, then idle for 50 clocks
    do_reset();
    bad = 1'b0;
    repeat (50) begin
      wait_clk(1);
      if (rot != 2'd0 || tick || running) bad = 1'b1;
    end
    check("idle_stable", int'(bad), 0);

    // auto-advance upward every 8 clocks
    c = cyc;
    run_en = 1'b1;
    push_exp(2'd1, c + 9);
    push_exp(2'd2, c + 17);
    push_exp(2'd3, c + 25);
    push_exp(2'd0, c + 33);
    push_exp(2'd1, c + 41);
    wait_clk(1);
    check("running_on", int'(running), 1);
    t0 = tick_cnt;
    wait_clk(33);
    check("ticks_in_32", tick_cnt - t0, 4);
    wait_clk(9);
    run_en = 1'b0;
    wait_clk(1);
    check("running_off", int'(running), 0);
    wait_clk(20);
    check("paused_rot_frozen", int'(rot), 1);

    // paused, clean press counting down: 0 -> 3 seven edges after first low sample
    do_reset();
    dir = 1'b1;
    c = cyc;
    step_n = 1'b0;
    push_exp(2'd3, c + 8);
    wait_clk(100);
    check("press_hold_rot", int'(rot), 3);
    step_n = 1'b1;
    wait_clk(20);
    check("release_rot", int'(rot), 3);

    // bouncy press: last stable low sample at edge c+3 -> advance at c+10
    dir = 1'b0;
    c = cyc;
    step_n = 1'b0;
    wait_clk(1);
    step_n = 1'b1;
    wait_clk(1);
    step_n = 1'b0;
    push_exp(2'd0, c + 10);
    wait_clk(30);
    check("bounce_press_rot", int'(rot), 0);
    step_n = 1'b1;
    wait_clk(1);
    step_n = 1'b0;
    wait_clk(1);
    step_n = 1'b1;
    wait_clk(30);
    check("bounce_release_rot", int'(rot), 0);

    // press pulse lands on the prescaler terminal count: one advance, period restarts
    c = cyc;
    run_en = 1'b1;
    push_exp(2'd1, c + 9);
    push_exp(2'd2, c + 17);
    wait_clk(1);
    step_n = 1'b0;
    wait_clk(19);
    run_en = 1'b0;
    step_n = 1'b1;
    wait_clk(1);
    check("mid_count_pause", int'(running), 0);
    wait_clk(10);
    check("mid_count_rot_frozen", int'(rot), 2);
    d = cyc;
    run_en = 1'b1;
    push_exp(2'd3, d + 9);

    // reset with debounce counter at 2 and prescaler at 5
    wait_clk(10);
    step_n = 1'b0;
    wait_clk(4);
    RESET  = 1'b1;
    step_n = 1'b1;
    run_en = 1'b0;
    wait_clk(1);
    check("midrst_rot", int'(rot), 0);
    check("midrst_tick", int'(tick), 0);
    check("midrst_running", int'(running), 0);
    wait_clk(1);
    RESET = 1'b0;
    wait_clk(30);
    check("post_rst_rot", int'(rot), 0);
    check("post_rst_running", int'(running), 0);

    wait_clk(2);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
